// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_pkg
// Brief   : Shared state encodings and defaults for the unified-memory arbiter.
// Revision: 1.0
// ============================================================================
package mem_arbiter_pkg;

    localparam logic [1:0] c_ST_IDLE   = 2'b00;
    localparam logic [1:0] c_ST_BUSY_I = 2'b01;
    localparam logic [1:0] c_ST_BUSY_D = 2'b10;

    localparam int c_STARVE_LIMIT_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_flopenr.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_flopenr
// Brief   : Enabled register with asynchronous active-high clear.
// Revision: 1.0
// ============================================================================
module mem_arbiter_flopenr #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Fetch/data arbiter for a single-port memory, data-priority with
//           a starvation counter guaranteeing fetch progress.
// Revision: 1.0
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = c_STARVE_LIMIT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          kill_f,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          stall_f,
    output logic          stall_m
);

    localparam int              c_CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(STARVE_LIMIT);

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_starve_cnt;
    logic            r_squash;
    logic            r_mem_req;
    logic            r_if_ack;
    logic            r_d_ack;

    logic            w_d_elig;
    logic            w_f_elig;
    logic            w_in_idle;
    logic            w_grant_f;
    logic            w_grant_d;
    logic            w_grant;
    logic            w_done_i;
    logic            w_done_d;
    logic            w_f_commit;
    logic            w_d_load;
    logic [AW-1:0]   w_nxt_addr;
    logic            w_nxt_we;
    logic [DW-1:0]   w_nxt_wdata;

    // The ack term keeps a just-served port from being re-granted in its ack cycle.
    assign w_d_elig  = d_req & ~r_d_ack;
    assign w_f_elig  = if_req & ~r_if_ack & ~kill_f;
    assign w_in_idle = (r_state == c_ST_IDLE);
    assign w_grant_f = w_in_idle & w_f_elig & (~w_d_elig | (r_starve_cnt == c_LIMIT));
    assign w_grant_d = w_in_idle & w_d_elig & ~w_grant_f;
    assign w_grant   = w_grant_f | w_grant_d;

    assign w_done_i   = (r_state == c_ST_BUSY_I) & mem_ready;
    assign w_done_d   = (r_state == c_ST_BUSY_D) & mem_ready;
    // A kill arriving together with mem_ready squashes the fetch as well.
    assign w_f_commit = w_done_i & ~r_squash & ~kill_f;
    assign w_d_load   = w_done_d & ~mem_we;

    assign w_nxt_addr  = w_grant_f ? if_addr : d_addr;
    assign w_nxt_we    = w_grant_d & d_we;
    assign w_nxt_wdata = w_grant_d ? d_wdata : '0;

    mem_arbiter_flopenr #(.WIDTH(AW)) u_mem_addr (
        .clk(clk), .rst(reset), .i_en(w_grant), .i_d(w_nxt_addr), .o_q(mem_addr)
    );
    mem_arbiter_flopenr #(.WIDTH(1)) u_mem_we (
        .clk(clk), .rst(reset), .i_en(w_grant), .i_d(w_nxt_we), .o_q(mem_we)
    );
    mem_arbiter_flopenr #(.WIDTH(DW)) u_mem_wdata (
        .clk(clk), .rst(reset), .i_en(w_grant), .i_d(w_nxt_wdata), .o_q(mem_wdata)
    );
    mem_arbiter_flopenr #(.WIDTH(DW)) u_if_rdata (
        .clk(clk), .rst(reset), .i_en(w_f_commit), .i_d(mem_rdata), .o_q(if_rdata)
    );
    mem_arbiter_flopenr #(.WIDTH(DW)) u_d_rdata (
        .clk(clk), .rst(reset), .i_en(w_d_load), .i_d(mem_rdata), .o_q(d_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_starve_cnt <= '0;
            r_squash     <= 1'b0;
            r_mem_req    <= 1'b0;
            r_if_ack     <= 1'b0;
            r_d_ack      <= 1'b0;
        end else begin
            r_if_ack <= w_f_commit;
            r_d_ack  <= w_done_d;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_f) begin
                        r_state      <= c_ST_BUSY_I;
                        r_mem_req    <= 1'b1;
                        r_starve_cnt <= '0;
                    end else if (w_grant_d) begin
                        r_state   <= c_ST_BUSY_D;
                        r_mem_req <= 1'b1;
                        if (!w_f_elig) begin
                            r_starve_cnt <= '0;
                        end else if (r_starve_cnt != c_LIMIT) begin
                            r_starve_cnt <= r_starve_cnt + c_CW'(1);
                        end
                    end
                end
                c_ST_BUSY_I: begin
                    if (mem_ready) begin
                        r_state   <= c_ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_squash  <= 1'b0;
                    end else if (kill_f) begin
                        r_squash <= 1'b1;
                    end
                end
                c_ST_BUSY_D: begin
                    if (mem_ready) begin
                        r_state   <= c_ST_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_mem_req <= 1'b0;
                    r_squash  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req = r_mem_req;
    assign if_ack  = r_if_ack;
    assign d_ack   = r_d_ack;
    assign stall_f = if_req & ~r_if_ack & ~kill_f;
    assign stall_m = d_req & ~r_d_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Directed scenarios plus randomized traffic against a
//           transaction-level model of the arbiter and a behavioural memory.
// Revision: 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int c_LIM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, kill_f, d_req, d_we, mem_ready;
    logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ack, d_ack, mem_req, mem_we, stall_f, stall_m;

    mem_arbiter #(.AW(16), .DW(16), .STARVE_LIMIT(c_LIM)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .kill_f(kill_f),
        .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_f(stall_f), .stall_m(stall_m)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Random-phase model state
    logic [15:0] gmem [0:511];
    int          cnt_m;
    logic        p_mreq, p_mready, p_delig, p_felig, p_dwe;
    logic [15:0] p_daddr, p_dwdata, p_faddr;
    logic        cur_fetch, cur_we, killed, exp_f;
    logic [15:0] hold_addr, last_rd;

    initial begin
        reset = 1'b1; if_req = 0; kill_f = 0; d_req = 0; d_we = 0; mem_ready = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        tick; tick;
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_acks", {if_ack, d_ack}, 0);
        check_eq("rst_rdata", {if_rdata, d_rdata}, 0);
        check_eq("rst_mem_bus", {mem_addr, mem_wdata, mem_we}, 0);
        reset = 1'b0;

        // Lone fetch
        if_req = 1; if_addr = 16'h0040; #1;
        check_eq("lone_stall_f", stall_f, 1);
        tick;
        check_eq("lone_req", mem_req, 1);
        check_eq("lone_addr", mem_addr, 16'h0040);
        check_eq("lone_we", mem_we, 0);
        check_eq("lone_stall_busy", stall_f, 1);
        mem_ready = 1; mem_rdata = 16'h1234;
        tick;
        check_eq("lone_ack", if_ack, 1);
        check_eq("lone_rdata", if_rdata, 16'h1234);
        check_eq("lone_stall_ack", stall_f, 0);
        if_req = 0; mem_ready = 0;
        tick;
        check_eq("lone_ack_pulse", if_ack, 0);

        // Contention: store wins, fetch granted in the d_ack cycle
        if_req = 1; if_addr = 16'h0044;
        d_req = 1; d_we = 1; d_addr = 16'h0100; d_wdata = 16'hBEEF;
        tick;
        check_eq("cont_data_first", mem_addr, 16'h0100);
        check_eq("cont_we", mem_we, 1);
        check_eq("cont_wdata", mem_wdata, 16'hBEEF);
        tick; tick;
        check_eq("cont_no_ack_yet", d_ack, 0);
        mem_ready = 1; mem_rdata = 16'h9999;
        tick;
        check_eq("cont_d_ack", d_ack, 1);
        d_req = 0; mem_ready = 0;
        tick;
        check_eq("cont_fetch_req", mem_req, 1);
        check_eq("cont_fetch_addr", mem_addr, 16'h0044);
        check_eq("cont_fetch_we", mem_we, 0);
        check_eq("cont_d_rdata_kept", d_rdata, 16'h0000);
        mem_ready = 1; mem_rdata = 16'h5678;
        tick;
        check_eq("cont_if_ack", if_ack, 1);
        check_eq("cont_if_rdata", if_rdata, 16'h5678);
        if_req = 0; mem_ready = 0;
        tick;

        // Kill in flight
        if_req = 1; if_addr = 16'h0050;
        tick;
        check_eq("kill_grant", mem_addr, 16'h0050);
        kill_f = 1;
        tick;
        kill_f = 0;
        tick; tick;
        mem_ready = 1; mem_rdata = 16'hDEAD;
        tick;
        check_eq("kill_done_req", mem_req, 0);
        check_eq("kill_no_ack", if_ack, 0);
        check_eq("kill_rdata_kept", if_rdata, 16'h5678);
        mem_ready = 0;
        tick;
        check_eq("kill_regrant", {mem_req, mem_addr}, {1'b1, 16'h0050});
        mem_ready = 1; mem_rdata = 16'h7777;
        tick;
        check_eq("kill_next_ack", if_ack, 1);
        check_eq("kill_next_rdata", if_rdata, 16'h7777);
        if_req = 0; mem_ready = 0;
        tick;

        // Starvation: kill_f in each d_ack cycle keeps fetch from slipping in
        if_req = 1; if_addr = 16'h0060;
        d_req = 1; d_we = 0; d_addr = 16'h0106;
        for (int k = 0; k < 5; k++) begin
            tick;
            check_eq($sformatf("starve_grant%0d", k), {mem_req, mem_addr},
                     {1'b1, (k < 4) ? 16'h0106 : 16'h0060});
            mem_ready = 1; mem_rdata = 16'(k);
            tick;
            check_eq($sformatf("starve_ack%0d", k), (k < 4) ? d_ack : if_ack, 1);
            mem_ready = 0;
            if (k < 4) begin
                kill_f = 1;
                tick;
                check_eq($sformatf("starve_gap%0d", k), mem_req, 0);
                kill_f = 0;
            end else begin
                if_req = 0;
            end
        end
        tick;
        check_eq("starve_data_resumes", {mem_req, mem_addr}, {1'b1, 16'h0106});
        mem_ready = 1;
        tick;
        d_req = 0; mem_ready = 0;
        tick;

        // Load data hold across a store
        d_req = 1; d_we = 0; d_addr = 16'h0200;
        tick;
        mem_ready = 1; mem_rdata = 16'h00FF;
        tick;
        check_eq("lw_ack", d_ack, 1);
        check_eq("lw_rdata", d_rdata, 16'h00FF);
        d_we = 1; d_addr = 16'h0202; d_wdata = 16'h1111; mem_ready = 0;
        tick;
        check_eq("sw_not_in_ack_cycle", mem_req, 0);
        tick;
        check_eq("sw_grant", {mem_req, mem_we}, 2'b11);
        mem_ready = 1; mem_rdata = 16'hABCD;
        tick;
        check_eq("sw_ack", d_ack, 1);
        check_eq("sw_rdata_hold", d_rdata, 16'h00FF);
        d_req = 0; mem_ready = 0;
        tick;

        // Asynchronous reset in BUSY_D
        d_req = 1; d_we = 0; d_addr = 16'h0204;
        tick;
        check_eq("ar_busy", mem_req, 1);
        #3 reset = 1;
        #1;
        check_eq("ar_req_drop", mem_req, 0);
        check_eq("ar_acks", {if_ack, d_ack}, 0);
        check_eq("ar_bus", mem_addr, 0);
        d_req = 0;
        @(posedge clk);
        #4 reset = 0;
        d_req = 1;
        tick;
        check_eq("ar_regrant", {mem_req, mem_addr}, {1'b1, 16'h0204});
        mem_ready = 1; mem_rdata = 16'h4242;
        tick;
        check_eq("ar_ack", d_ack, 1);
        check_eq("ar_rdata", d_rdata, 16'h4242);
        d_req = 0; mem_ready = 0;
        tick;

        // Randomized traffic: fetch region 0x000-0x0FF, data region 0x100-0x10F
        for (int i = 0; i < 512; i++) gmem[i] = 16'($urandom);
        cnt_m = 0; p_mreq = 0; p_mready = 0; p_delig = 0; p_felig = 0;
        p_dwe = 0; p_daddr = 0; p_dwdata = 0; p_faddr = 0;
        cur_fetch = 0; cur_we = 0; killed = 0; hold_addr = 0; last_rd = 16'h4242;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick;
            if (!p_mreq) begin
                check_eq("r_no_ack_idle", {if_ack, d_ack}, 0);
                if (p_delig || p_felig) begin
                    exp_f = p_felig && (!p_delig || cnt_m == c_LIM);
                    check_eq("r_grant_req", mem_req, 1);
                    if (exp_f) begin
                        check_eq("r_grant_fetch", {mem_addr, mem_we}, {p_faddr, 1'b0});
                        cnt_m = 0; cur_fetch = 1; cur_we = 0; killed = 0; hold_addr = p_faddr;
                    end else begin
                        check_eq("r_grant_data", {mem_addr, mem_we}, {p_daddr, p_dwe});
                        if (p_dwe) check_eq("r_grant_wdata", mem_wdata, p_dwdata);
                        cnt_m = p_felig ? ((cnt_m < c_LIM) ? cnt_m + 1 : c_LIM) : 0;
                        cur_fetch = 0; cur_we = p_dwe; hold_addr = p_daddr;
                    end
                end else begin
                    check_eq("r_idle_no_req", mem_req, 0);
                end
            end else if (!p_mready) begin
                check_eq("r_hold", {mem_req, mem_addr}, {1'b1, hold_addr});
                check_eq("r_no_ack_busy", {if_ack, d_ack}, 0);
            end else begin
                check_eq("r_done_req", mem_req, 0);
                if (cur_fetch) begin
                    check_eq("r_if_ack", {if_ack, d_ack}, {!killed, 1'b0});
                    if (!killed) check_eq("r_if_rdata", if_rdata, gmem[hold_addr[8:0]]);
                end else begin
                    check_eq("r_d_ack", {if_ack, d_ack}, 2'b01);
                    if (!cur_we) last_rd = gmem[hold_addr[8:0]];
                    check_eq("r_d_rdata", d_rdata, last_rd);
                end
            end

            if (if_ack) begin
                if_req = 1'($urandom_range(0, 1)); if_addr = 16'($urandom_range(0, 255));
            end else if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req = 1; if_addr = 16'($urandom_range(0, 255));
            end
            if (d_ack || (!d_req && $urandom_range(0, 2) == 0)) begin
                d_req = d_ack ? 1'($urandom_range(0, 1)) : 1'b1;
                d_we = 1'($urandom_range(0, 1));
                d_addr = 16'h0100 + 16'($urandom_range(0, 15));
                d_wdata = 16'($urandom);
            end
            kill_f = ($urandom_range(0, 5) == 0);
            if (mem_req) begin
                mem_ready = ($urandom_range(0, 2) == 0);
                if (mem_ready) begin
                    mem_rdata = gmem[mem_addr[8:0]];
                    if (mem_we) gmem[mem_addr[8:0]] = mem_wdata;
                end
                if (cur_fetch && kill_f) killed = 1;
            end else begin
                mem_ready = ($urandom_range(0, 3) == 0);
                mem_rdata = 16'($urandom);
            end

            p_mreq = mem_req; p_mready = mem_ready;
            p_delig = d_req & ~d_ack; p_felig = if_req & ~if_ack & ~kill_f;
            p_dwe = d_we; p_daddr = d_addr; p_dwdata = d_wdata; p_faddr = if_addr;
            #1;
            check_eq("r_stall", {stall_f, stall_m}, {p_felig, p_delig});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
